// File: rtl/des_key_pkg.sv
// Shared definitions for the 3DES round-key packer and group selector.
// Both blocks use the same packing: slot k sits at [1151-48k -: 48].
package des_key_pkg;

    localparam int KEY_W      = 48;
    localparam int NUM_KEYS   = 24;
    localparam int GROUP      = 6;
    localparam int NUM_GROUPS = NUM_KEYS / GROUP;
    localparam int VEC_W      = NUM_KEYS * KEY_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } packer_state_t;

    // MSB bit index of slot k within the packed vector; slot 0 is the top key.
    function automatic int slot_msb(input int k);
        return VEC_W - 1 - KEY_W * k;
    endfunction

endpackage

// File: rtl/round_key_packer.sv
// Sequential writer that packs 24 round keys into a 1152-bit bus with
// per-group completion flags so the round pipeline can start early.
module round_key_packer
    import des_key_pkg::*;
#(
    parameter int NUM_KEYS = des_key_pkg::NUM_KEYS,
    parameter int KEY_W    = des_key_pkg::KEY_W,
    parameter int GROUP    = des_key_pkg::GROUP
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [KEY_W-1:0]            key_in,
    input  logic                        key_valid,
    output logic                        key_ready,
    input  logic                        consume,
    output logic [NUM_KEYS*KEY_W-1:0]   round_keys,
    output logic [NUM_KEYS/GROUP-1:0]   group_ready,
    output logic                        keys_full,
    output logic [$clog2(NUM_KEYS+1)-1:0] load_count
);

    localparam int CNT_W  = $clog2(NUM_KEYS + 1);
    localparam int N_GRPS = NUM_KEYS / GROUP;

    packer_state_t state;
    packer_state_t state_next;
    logic          key_fire;

    // A start in the same cycle aborts the load, so the key is refused.
    assign key_ready = (state == ST_FILL) && !start;
    assign key_fire  = key_valid && key_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_FILL;
        end else begin
            case (state)
                ST_IDLE: state_next = ST_IDLE;
                ST_FILL: if (key_fire && load_count == CNT_W'(NUM_KEYS - 1)) state_next = ST_FULL;
                ST_FULL: if (consume) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // NOTE: the key store is plain flops, not a RAM, so it takes the synchronous reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            round_keys  <= '0;
            group_ready <= '0;
            keys_full   <= 1'b0;
            load_count  <= '0;
        end else begin
            state     <= state_next;
            keys_full <= (state_next == ST_FULL);
            if (start) begin
                round_keys  <= '0;
                group_ready <= '0;
                load_count  <= '0;
            end else if (key_fire) begin
                load_count <= load_count + CNT_W'(1);
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (load_count == CNT_W'(k)) begin
                        round_keys[slot_msb(k) -: KEY_W] <= key_in;
                    end
                end
                // A group completes on the write of its last slot.
                for (int g = 0; g < N_GRPS; g++) begin
                    if (load_count == CNT_W'(g * GROUP + GROUP - 1)) begin
                        group_ready[g] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_round_key_packer.sv
// Self-checking bench for round_key_packer: directed scenarios plus a
// randomized phase, all compared against a slot-array reference model.
module tb_round_key_packer;
    import des_key_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [KEY_W-1:0]          key_in;
    logic                      key_valid;
    logic                      key_ready;
    logic                      consume;
    logic [NUM_KEYS*KEY_W-1:0] round_keys;
    logic [NUM_GROUPS-1:0]     group_ready;
    logic                      keys_full;
    logic [4:0]                load_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the keys written so far, how many, and the phase flags.
    logic [KEY_W-1:0] m_slots [NUM_KEYS];
    int               m_count;
    bit               m_loading;
    bit               m_full;
    bit               m_accepted;

    always #5 clk = ~clk;

    round_key_packer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .consume    (consume),
        .round_keys (round_keys),
        .group_ready(group_ready),
        .keys_full  (keys_full),
        .load_count (load_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [KEY_W-1:0] rand_key();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[KEY_W-1:0];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NUM_KEYS; k++) m_slots[k] = '0;
        m_count = 0;
    endtask

    // Applies the inputs present at a rising edge to the model.
    task automatic model_step();
        m_accepted = 1'b0;
        if (rst) begin
            model_clear();
            m_loading = 1'b0;
            m_full    = 1'b0;
        end else if (start) begin
            model_clear();
            m_loading = 1'b1;
            m_full    = 1'b0;
        end else if (m_loading && key_valid) begin
            m_slots[m_count] = key_in;
            m_count++;
            m_accepted = 1'b1;
            if (m_count == NUM_KEYS) begin
                m_loading = 1'b0;
                m_full    = 1'b1;
            end
        end else if (m_full && consume) begin
            m_full = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NUM_KEYS; k++) begin
            check($sformatf("slot%0d", k),
                  round_keys[NUM_KEYS*KEY_W-1-KEY_W*k -: KEY_W], m_slots[k]);
        end
        for (int g = 0; g < NUM_GROUPS; g++) begin
            check($sformatf("group_ready[%0d]", g), group_ready[g], m_count >= GROUP * (g + 1));
        end
        check("load_count", load_count, m_count);
        check("keys_full", keys_full, m_full);
    endtask

    // One clock: check key_ready mid-cycle, advance the model at the edge,
    // then check the registered outputs shortly after.
    task automatic cycle();
        @(negedge clk);
        check("key_ready", key_ready, m_loading && !start);
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic load_keys(input int n);
        for (int i = 0; i < n; i++) begin
            key_valid = 1'b1;
            key_in    = rand_key();
            cycle();
        end
        key_valid = 1'b0;
    endtask

    initial begin
        logic [NUM_KEYS*KEY_W-1:0] saved;
        logic [KEY_W-1:0]          first_key;
        int                        idx;
        int                        lat;

        rst = 1'b1; start = 1'b0; key_in = '0; key_valid = 1'b0; consume = 1'b0;
        m_loading = 1'b0; m_full = 1'b0; m_accepted = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check("reset_key_ready", key_ready, 1'b0);
        check("reset_group", group_ready, 4'b0000);
        rst = 1'b0;
        cycle();

        // Fastest load with keys 1..24.
        pulse_start();
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_valid = 1'b1;
            key_in    = KEY_W'(i + 1);
            cycle();
            if (i == NUM_KEYS - 2) check("full_early", keys_full, 1'b0);
        end
        key_valid = 1'b0;
        check("full_after_24", keys_full, 1'b1);
        check("first_slot", round_keys[1151:1104], 48'h1);
        check("last_slot", round_keys[47:0], 48'h18);
        check("count_24", load_count, 5'd24);
        saved = round_keys;
        cycle();

        // Same load, key_valid low every other cycle.
        pulse_start();
        idx = 0;
        lat = 0;
        for (int e = 1; e <= 100; e++) begin
            key_valid = (e % 2 == 1) && (idx < NUM_KEYS);
            key_in    = KEY_W'(idx + 1);
            cycle();
            if (key_valid) begin
                idx++;
                if (idx % GROUP == 0)
                    check($sformatf("group_after_%0d", idx), group_ready, (1 << (idx / GROUP)) - 1);
            end
            if (keys_full) begin
                lat = e;
                break;
            end
        end
        key_valid = 1'b0;
        check("full_latency", lat, 47);
        check("same_keys", round_keys == saved, 1'b1);

        // start in the middle of a load aborts it.
        pulse_start();
        load_keys(10);
        check("group_at_10", group_ready, 4'b0001);
        key_valid = 1'b1;
        key_in    = rand_key();
        first_key = key_in;
        start     = 1'b1;
        #1;
        check("ready_during_start", key_ready, 1'b0);
        cycle();
        start = 1'b0;
        check("abort_count", load_count, 5'd0);
        check("abort_group", group_ready, 4'b0000);
        check("abort_clear", round_keys == '0, 1'b1);
        cycle();
        load_keys(NUM_KEYS - 1);
        check("reload_slot0", round_keys[1151:1104], first_key);
        check("reload_full", keys_full, 1'b1);

        // FULL ignores further keys, then consume retains them.
        saved     = round_keys;
        key_valid = 1'b1;
        key_in    = 48'hFFFF_FFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("full_hold_ready", key_ready, 1'b0);
            check("full_hold_keys", round_keys == saved, 1'b1);
        end
        key_valid = 1'b0;
        consume   = 1'b1;
        cycle();
        consume = 1'b0;
        check("consume_full", keys_full, 1'b0);
        check("consume_keys", round_keys == saved, 1'b1);
        check("consume_group", group_ready, 4'b1111);
        cycle();
        check("idle_ready", key_ready, 1'b0);

        // rst in the middle of a load.
        pulse_start();
        load_keys(15);
        key_valid = 1'b1;
        key_in    = rand_key();
        rst       = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_count", load_count, 5'd0);
        check("rst_group", group_ready, 4'b0000);
        check("rst_keys", round_keys == '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_ready", key_ready, 1'b0);
            cycle();
        end
        key_valid = 1'b0;

        // start and consume together in FULL: start wins.
        pulse_start();
        load_keys(NUM_KEYS);
        check("pre_sc_full", keys_full, 1'b1);
        start   = 1'b1;
        consume = 1'b1;
        cycle();
        start   = 1'b0;
        consume = 1'b0;
        check("sc_full", keys_full, 1'b0);
        check("sc_count", load_count, 5'd0);
        check("sc_keys", round_keys == '0, 1'b1);
        #1;
        check("sc_ready", key_ready, 1'b1);

        // Randomized traffic; a refused key is held until accepted.
        for (int i = 0; i < 500; i++) begin
            start   = ($urandom_range(0, 29) == 0);
            consume = ($urandom_range(0, 5) == 0);
            rst     = ($urandom_range(0, 149) == 0);
            if (!(key_valid && !m_accepted) || rst) begin
                key_valid = ($urandom_range(0, 3) != 0);
                key_in    = rand_key();
            end
            cycle();
        end
        start = 1'b0; consume = 1'b0; rst = 1'b0; key_valid = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/round_key_packer.md
# round_key_packer

Sequential writer for the packed 3DES round-key bus. It accepts 48-bit round keys one at a time from the key-schedule generator over a valid/ready handshake and stores each key in its slot of a 1152-bit vector (24 keys). Per-group completion flags let the datapath start on group 0 while later keys are still loading. The packed vector and flags feed the 6-key group selector that the round pipeline reads with its 2-bit group count.

## Interface
Parameters:
- NUM_KEYS, 24, number of round-key slots.
- KEY_W, 48, width of one round key.
- GROUP, 6, keys per group; NUM_KEYS/GROUP = 4 groups.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: clear the store and begin a new load.
- key_in  in  48  round key presented by the scheduler.
- key_valid  in  1  key_in is valid this cycle.
- key_ready  out  1  packer accepts key_in this cycle.
- consume  in  1  downstream has finished with a full key set.
- round_keys  out  1152  packed keys; slot k occupies [1151-48k -: 48].
- group_ready  out  4  bit g set once slots 6g..6g+5 are all written.
- keys_full  out  1  all 24 slots written.
- load_count  out  5  number of keys written since the last start, 0..24.

## Operation
- States: IDLE, FILL, FULL.
- IDLE: key_ready=0. start moves to FILL and clears the store.
- FILL: key_ready = !start, combinational.
  - Handshake is key_valid && key_ready. On a handshake, write key_in to slot load_count, then load_count++.
  - A handshake with load_count==23 moves to FILL→FULL.
- FULL: key_ready=0 and keys_full=1.
  - consume → IDLE; round_keys and group_ready are kept.
  - start → FILL; store is cleared.
  - If start and consume are both asserted, start wins.
- Clear on start, from any state: round_keys=0, group_ready=0, load_count=0.
- start during FILL: abort the current load and restart from slot 0. A key presented in the same cycle is not accepted (key_ready=0).
- group_ready[g] sets on the handshake that writes slot 6g+5. It stays set until start or rst.
- key_valid while key_ready=0 is ignored. The scheduler must hold key_in/key_valid until the handshake.
- consume outside FULL is ignored.
- Slots are written in order only. No overwrite is possible until the next start.

## Timing
- Reset values: state=IDLE, round_keys=0, group_ready=0, keys_full=0, load_count=0, key_ready=0.
- rst mid-load: the next cycle is in reset state and partial keys are discarded.
- Key write latency is 1 cycle. A slot accepted at edge N is visible on round_keys after edge N.
- group_ready, load_count and keys_full update on the same edge as the write.
- Fastest load:
  - start in cycle 0.
  - key_ready=1 from cycle 1.
  - 24 back-to-back handshakes in cycles 1..24.
  - keys_full=1 from cycle 25.
- Throughput: 1 key per cycle. Stalls from key_valid=0 insert cycles with no state change.
- All outputs are registered except key_ready.

## Structure
- Shared package des_key_pkg holds:
  - KEY_W, NUM_KEYS, GROUP, and the derived NUM_GROUPS=4;
  - the state enum typedef;
  - the slot-to-bit-offset function (1151-48k), shared with the group selector so both blocks agree on packing.
- Single module, no sub-modules. The state register, the 5-bit counter and the slot write-enable decode fit in one block.

## Test plan
- Reset then start, then 24 back-to-back keys 48'h000000000001..48'h000000000018:
  - round_keys[1151:1104]=48'h1 and [47:0]=48'h18;
  - keys_full rises the cycle after the 24th handshake;
  - load_count=24.
- Same load with key_valid low every other cycle:
  - identical final round_keys;
  - keys_full 47 cycles after start;
  - group_ready bits rise after the 6th, 12th, 18th and 24th keys.
- start pulsed after 10 keys (group_ready=4'b0001), key_valid held high through it:
  - key_ready=0 that cycle;
  - round_keys=0, group_ready=0, load_count=0 next cycle;
  - the reload fills from slot 0.
- In FULL, hold key_valid=1 with key_in=48'hFFFFFFFFFFFF for 5 cycles:
  - key_ready stays 0 and round_keys is unchanged;
  - then consume → IDLE with keys retained.
- rst asserted after 15 keys: all outputs return to reset values the next cycle, and key_ready=0 until start.
- start and consume together in FULL: FILL entered, store cleared, keys_full=0 next cycle.
